// File: rtl/gpr_write_scheduler.sv
// gpr_write_scheduler
// Shares the two GPR file write ports (X and Y) among NREQ requesters.
// Each cycle up to two requests are granted in round-robin order. X is
// always filled before Y, and the two grants never target the same
// register. Port fields are registered one cycle after the grant.
//
// Ports:
//   clock                   rising-edge clock
//   reset                   asynchronous, active-high reset
//   hold                    freeze: no grants this cycle
//   req_valid[NREQ]         request i has a write pending
//   req_addr[NREQ*AW]       request i target register, slice [i*AW +: AW]
//   req_data[NREQ*DW]       request i write data, slice [i*DW +: DW]
//   req_ready[NREQ]         combinational grant (transfer = valid & ready)
//   WrtAdrX/WrtEnbX/X       registered X write port
//   WrtAdrY/WrtEnbY/Y       registered Y write port
//   pend_mask[2**AW]        one-hot OR of registers being written this cycle
//   wr_count[16]            committed writes, wraps modulo 2**16
module gpr_write_scheduler #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int AW   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      WrtAdrX,
  output logic               WrtEnbX,
  output logic [DW-1:0]      X,
  output logic [AW-1:0]      WrtAdrY,
  output logic               WrtEnbY,
  output logic [DW-1:0]      Y,
  output logic [2**AW-1:0]   pend_mask,
  output logic [15:0]        wr_count
);

  localparam int PW   = $clog2(NREQ);
  localparam int NREG = 2**AW;

  logic [PW-1:0]   rr_ptr_r;
  logic [PW-1:0]   rr_next_s;
  logic [PW-1:0]   idx_s;
  logic [PW-1:0]   g0_idx_s;
  logic [PW-1:0]   g1_idx_s;
  logic            g0_found_s;
  logic            g1_found_s;
  logic [AW-1:0]   addr_s [NREQ];
  logic [DW-1:0]   data_s [NREQ];
  logic [NREG-1:0] mask_next_s;

  // (base + offs) mod NREQ; offs never exceeds NREQ so one subtraction suffices.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input int unsigned offs);
    int unsigned sum;
    sum = {{(32-PW){1'b0}}, base} + offs;
    if (sum >= 32'(NREQ)) begin
      sum = sum - 32'(NREQ);
    end else begin
      sum = sum;
    end
    return sum[PW-1:0];
  endfunction

  // Unpack the flat request buses into per-requester arrays.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_s[i] = req_addr[i*AW +: AW];
      data_s[i] = req_data[i*DW +: DW];
    end
  end

  // Round-robin scan: first valid request takes X, next valid request with a
  // different address takes Y. Same-address requests are skipped, not granted.
  always_comb begin
    req_ready  = {NREQ{1'b0}};
    g0_found_s = 1'b0;
    g1_found_s = 1'b0;
    g0_idx_s   = {PW{1'b0}};
    g1_idx_s   = {PW{1'b0}};
    idx_s      = {PW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      idx_s = wrap_add(rr_ptr_r, k);
      if (hold || reset || !req_valid[idx_s]) begin
        req_ready = req_ready;
      end else if (!g0_found_s) begin
        g0_found_s       = 1'b1;
        g0_idx_s         = idx_s;
        req_ready[idx_s] = 1'b1;
      end else if (!g1_found_s && (addr_s[idx_s] != addr_s[g0_idx_s])) begin
        g1_found_s       = 1'b1;
        g1_idx_s         = idx_s;
        req_ready[idx_s] = 1'b1;
      end else begin
        req_ready = req_ready;
      end
    end
  end

  // Next pointer (one past the last grant in scan order) and next pending mask.
  always_comb begin
    mask_next_s = {NREG{1'b0}};
    if (g0_found_s) begin
      mask_next_s[addr_s[g0_idx_s]] = 1'b1;
    end else begin
      mask_next_s = mask_next_s;
    end
    if (g1_found_s) begin
      mask_next_s[addr_s[g1_idx_s]] = 1'b1;
    end else begin
      mask_next_s = mask_next_s;
    end
    if (g1_found_s) begin
      rr_next_s = wrap_add(g1_idx_s, 32'd1);
    end else if (g0_found_s) begin
      rr_next_s = wrap_add(g0_idx_s, 32'd1);
    end else begin
      rr_next_s = rr_ptr_r;
    end
  end

  // Write-port registers, round-robin pointer and committed-write counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_r  <= {PW{1'b0}};
      WrtEnbX   <= 1'b0;
      WrtAdrX   <= {AW{1'b0}};
      X         <= {DW{1'b0}};
      WrtEnbY   <= 1'b0;
      WrtAdrY   <= {AW{1'b0}};
      Y         <= {DW{1'b0}};
      pend_mask <= {NREG{1'b0}};
      wr_count  <= 16'h0000;
    end else begin
      rr_ptr_r  <= rr_next_s;
      pend_mask <= mask_next_s;
      // Counts the writes currently on the ports, independent of hold.
      wr_count  <= wr_count + {15'b0, WrtEnbX} + {15'b0, WrtEnbY};
      WrtEnbX   <= g0_found_s;
      WrtEnbY   <= g1_found_s;
      if (g0_found_s) begin
        WrtAdrX <= addr_s[g0_idx_s];
        X       <= data_s[g0_idx_s];
      end else begin
        WrtAdrX <= WrtAdrX;
        X       <= X;
      end
      if (g1_found_s) begin
        WrtAdrY <= addr_s[g1_idx_s];
        Y       <= data_s[g1_idx_s];
      end else begin
        WrtAdrY <= WrtAdrY;
        Y       <= Y;
      end
    end
  end

endmodule

// File: tb/tb_gpr_write_scheduler.sv
// Directed testbench for gpr_write_scheduler (NREQ=4, DW=32, AW=4).
module tb_gpr_write_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               hold;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      WrtAdrX;
  logic               WrtEnbX;
  logic [DW-1:0]      X;
  logic [AW-1:0]      WrtAdrY;
  logic               WrtEnbY;
  logic [DW-1:0]      Y;
  logic [2**AW-1:0]   pend_mask;
  logic [15:0]        wr_count;

  int checks = 0;
  int errors = 0;

  gpr_write_scheduler #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clock(clock), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .WrtAdrX(WrtAdrX), .WrtEnbX(WrtEnbX), .X(X),
    .WrtAdrY(WrtAdrY), .WrtEnbY(WrtEnbY), .Y(Y),
    .pend_mask(pend_mask), .wr_count(wr_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ports(input string tag,
                           input logic ex, input logic [3:0] ax, input logic [31:0] dx,
                           input logic ey, input logic [3:0] ay, input logic [31:0] dy,
                           input logic [15:0] pm, input logic [15:0] cnt);
    check({tag, ".enbx"}, {63'd0, WrtEnbX}, {63'd0, ex});
    check({tag, ".adrx"}, {60'd0, WrtAdrX}, {60'd0, ax});
    check({tag, ".x"},    {32'd0, X},       {32'd0, dx});
    check({tag, ".enby"}, {63'd0, WrtEnbY}, {63'd0, ey});
    check({tag, ".adry"}, {60'd0, WrtAdrY}, {60'd0, ay});
    check({tag, ".y"},    {32'd0, Y},       {32'd0, dy});
    check({tag, ".pend"}, {48'd0, pend_mask}, {48'd0, pm});
    check({tag, ".cnt"},  {48'd0, wr_count},  {48'd0, cnt});
  endtask

  task automatic chk_ready(input string tag, input logic [3:0] exp);
    #1;
    check({tag, ".ready"}, {60'd0, req_ready}, {60'd0, exp});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [31:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    reset     = 1'b1;
    hold      = 1'b0;
    req_valid = 4'b0000;
    req_addr  = 16'h0000;
    req_data  = 128'd0;
    step();
    step();
    reset = 1'b0;
    chk_ports("rst", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 16'h0000, 16'd0);

    // Round-robin: four distinct addresses, all valid for four cycles
    set_req(0, 4'd1, 32'hA0); set_req(1, 4'd2, 32'hA1);
    set_req(2, 4'd3, 32'hA2); set_req(3, 4'd4, 32'hA3);
    req_valid = 4'b1111;
    chk_ready("rr0", 4'b0011);
    step();
    chk_ports("rr1", 1'b1, 4'd1, 32'hA0, 1'b1, 4'd2, 32'hA1, 16'h0006, 16'd0);
    chk_ready("rr1", 4'b1100);
    step();
    chk_ports("rr2", 1'b1, 4'd3, 32'hA2, 1'b1, 4'd4, 32'hA3, 16'h0018, 16'd2);
    chk_ready("rr2", 4'b0011);
    step();
    chk_ports("rr3", 1'b1, 4'd1, 32'hA0, 1'b1, 4'd2, 32'hA1, 16'h0006, 16'd4);
    step();
    chk_ports("rr4", 1'b1, 4'd3, 32'hA2, 1'b1, 4'd4, 32'hA3, 16'h0018, 16'd6);
    req_valid = 4'b0000;
    step();
    chk_ports("rr5", 1'b0, 4'd3, 32'hA2, 1'b0, 4'd4, 32'hA3, 16'h0000, 16'd8);

    // Address conflict: requesters 0 and 1 both target r5, requester 2 targets r7
    set_req(0, 4'd5, 32'h11); set_req(1, 4'd5, 32'h22); set_req(2, 4'd7, 32'h33);
    req_valid = 4'b0111;
    chk_ready("cf0", 4'b0101);
    step();
    chk_ports("cf1", 1'b1, 4'd5, 32'h11, 1'b1, 4'd7, 32'h33, 16'h00A0, 16'd8);
    req_valid = 4'b0010;
    chk_ready("cf1", 4'b0010);
    step();
    chk_ports("cf2", 1'b1, 4'd5, 32'h22, 1'b0, 4'd7, 32'h33, 16'h0020, 16'd10);
    req_valid = 4'b0000;
    step();
    chk_ports("cf3", 1'b0, 4'd5, 32'h22, 1'b0, 4'd7, 32'h33, 16'h0000, 16'd11);

    // Single requester: only requester 3 valid for three cycles
    set_req(3, 4'd9, 32'hD0);
    req_valid = 4'b1000;
    chk_ready("sg0", 4'b1000);
    step();
    chk_ports("sg1", 1'b1, 4'd9, 32'hD0, 1'b0, 4'd7, 32'h33, 16'h0200, 16'd11);
    set_req(3, 4'd9, 32'hD1);
    chk_ready("sg1", 4'b1000);
    step();
    chk_ports("sg2", 1'b1, 4'd9, 32'hD1, 1'b0, 4'd7, 32'h33, 16'h0200, 16'd12);
    set_req(3, 4'd9, 32'hD2);
    step();
    chk_ports("sg3", 1'b1, 4'd9, 32'hD2, 1'b0, 4'd7, 32'h33, 16'h0200, 16'd13);
    req_valid = 4'b0000;
    step();
    chk_ports("sg4", 1'b0, 4'd9, 32'hD2, 1'b0, 4'd7, 32'h33, 16'h0000, 16'd14);

    // Hold for two cycles while requests are pending
    set_req(0, 4'd1, 32'hB0); set_req(1, 4'd2, 32'hB1);
    set_req(2, 4'd3, 32'hB2); set_req(3, 4'd4, 32'hB3);
    req_valid = 4'b1111;
    chk_ready("hd0", 4'b0011);
    step();
    chk_ports("hd1", 1'b1, 4'd1, 32'hB0, 1'b1, 4'd2, 32'hB1, 16'h0006, 16'd14);
    hold = 1'b1;
    chk_ready("hd1", 4'b0000);
    step();
    chk_ports("hd2", 1'b0, 4'd1, 32'hB0, 1'b0, 4'd2, 32'hB1, 16'h0000, 16'd16);
    chk_ready("hd2", 4'b0000);
    step();
    chk_ports("hd3", 1'b0, 4'd1, 32'hB0, 1'b0, 4'd2, 32'hB1, 16'h0000, 16'd16);
    hold = 1'b0;
    chk_ready("hd3", 4'b1100);
    step();
    chk_ports("hd4", 1'b1, 4'd3, 32'hB2, 1'b1, 4'd4, 32'hB3, 16'h0018, 16'd16);
    chk_ready("hd4", 4'b0011);
    step();
    chk_ports("hd5", 1'b1, 4'd1, 32'hB0, 1'b1, 4'd2, 32'hB1, 16'h0006, 16'd18);

    // Asynchronous reset mid-cycle with all requesters valid
    #2;
    reset = 1'b1;
    #1;
    chk_ports("arst", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 16'h0000, 16'd0);
    check("arst.ready", {60'd0, req_ready}, 64'd0);
    step();
    reset = 1'b0;
    chk_ready("arst1", 4'b0011);
    step();
    chk_ports("arst2", 1'b1, 4'd1, 32'hB0, 1'b1, 4'd2, 32'hB1, 16'h0006, 16'd0);

    // Counter wrap: one single write, then a run of dual writes
    req_valid = 4'b0001;
    chk_ready("wr0", 4'b0001);
    step();
    chk_ports("wr1", 1'b1, 4'd1, 32'hB0, 1'b0, 4'd2, 32'hB1, 16'h0002, 16'd2);
    req_valid = 4'b1111;
    chk_ready("wr1", 4'b0110);
    step();
    chk_ports("wr2", 1'b1, 4'd2, 32'hB1, 1'b1, 4'd3, 32'hB2, 16'h000C, 16'd3);
    repeat (32766) step();
    check("wr.ffff", {48'd0, wr_count}, {48'd0, 16'hFFFF});
    check("wr.dual", {62'd0, WrtEnbX, WrtEnbY}, 64'd3);
    step();
    check("wr.wrap", {48'd0, wr_count}, {48'd0, 16'h0001});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_write_scheduler.md
Name: gpr_write_scheduler

Overview:
- Shares the two register-file write ports (X and Y) among NREQ independent requesters, such as execution units and load return paths.
- Each cycle it grants up to two requests in round-robin order and drives registered write address, enable and data to the GPR file.
- Two writes to the same register are never issued in one cycle, so the GPR file's X-over-Y tie-break is never relied on.
- Also exports a pending-write mask and a committed-write counter for hazard logic and debug.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, data width.
- AW, 4, register address width (16 GPRs).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- hold  in  1  freeze: no grants this cycle.
- req_valid  in  NREQ  request i has a write pending.
- req_addr  in  NREQ*AW  request i target register; slice i at [i*AW +: AW].
- req_data  in  NREQ*DW  request i write data; slice i at [i*DW +: DW].
- req_ready  out  NREQ  combinational grant; a transfer occurs when req_valid[i] & req_ready[i].
- WrtAdrX  out  AW  X-port address (registered).
- WrtEnbX  out  1  X-port enable (registered).
- X  out  DW  X-port data (registered).
- WrtAdrY  out  AW  Y-port address (registered).
- WrtEnbY  out  1  Y-port enable (registered).
- Y  out  DW  Y-port data (registered).
- pend_mask  out  2**AW  one-hot OR of the registers currently being written by the enabled X/Y outputs.
- wr_count  out  16  committed writes, wraps modulo 2**16.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - WrtEnbX/Y=0, WrtAdrX/Y=0, X=Y=0, rr_ptr=0, wr_count=0.
  - req_ready=0 while reset is asserted.
  - Any grant in flight is dropped; requesters must hold req_valid until they see ready.
- Arbitration (combinational, each cycle, hold=0):
  - Scan i = rr_ptr, rr_ptr+1, ... modulo NREQ.
  - First valid request becomes G0 and is assigned to port X.
  - Next valid request whose address differs from G0's becomes G1 and is assigned to port Y.
  - A valid request with the same address as G0 is skipped and stays pending; the scan continues past it.
  - req_ready is 1 only for G0 and G1.
- Output register:
  - At the clock edge, X-port fields load from G0 (WrtEnbX=1), or WrtEnbX loads 0 if there is no G0.
  - Y-port fields load from G1 the same way.
  - When an enable is 0, the corresponding address and data hold their previous values.
  - Latency: a request accepted in cycle n appears on the port in cycle n+1 and lands in the GPR file at the end of cycle n+1.
- Round-robin pointer:
  - After a cycle with grants, rr_ptr = (index of last granted requester + 1) mod NREQ.
  - After a cycle with no grants, rr_ptr is unchanged.
  - A requester that is skipped for an address conflict keeps its place; it is first in line on the next scan if the pointer reaches it.
- hold=1:
  - req_ready=0 for all requesters.
  - Next cycle WrtEnbX=WrtEnbY=0.
  - rr_ptr is unchanged.
  - wr_count still counts writes already registered in the current cycle.
- wr_count increments each cycle by WrtEnbX + WrtEnbY (0, 1 or 2).
  - Wrap-around: 16'hFFFF + 1 = 16'h0000; 16'hFFFF + 2 = 16'h0001.
- pend_mask:
  - Bit WrtAdrX is set if WrtEnbX=1; bit WrtAdrY is set if WrtEnbY=1.
  - All zero when both enables are 0.
- X port is always used before Y: WrtEnbY=1 implies WrtEnbX=1.
- Starvation freedom: any continuously valid request is granted within NREQ cycles, provided hold=0 and no conflicting writer targets the same register every cycle.

Test Plan:
- Reset checks:
  - Assert reset asynchronously mid-cycle with all four requesters valid → all outputs 0 immediately, req_ready=0.
  - Release reset, then first grant goes to requester 0 on X and requester 1 on Y.
- Round-robin:
  - All 4 valid with addresses 1, 2, 3, 4 and data A0..A3 held for 4 cycles.
  - Grants go (0,1), (2,3), (0,1), ... → X/Y show addresses 1/2 then 3/4; wr_count reaches 8 after 4 issuing cycles.
- Address conflict:
  - Requesters 0 and 1 both target register 5 with data 11 and 22; requester 2 targets register 7.
  - Cycle 1: X=5/11, Y=7 from requester 2.
  - Cycle 2: X=5/22, Y disabled.
  - pend_mask = 0x00A0 in cycle 1, then 0x0020 in cycle 2.
- Single requester: only requester 3 is valid for 3 cycles → only X is used, WrtEnbY stays 0, wr_count increments by 1 per cycle.
- Hold: assert hold for 2 cycles with requests pending → req_ready=0, enables drop the next cycle, rr_ptr is preserved, and grants resume in the same order after hold is released.
- Counter wrap: preload wr_count to 16'hFFFF via a run of writes, then issue a dual write → wr_count = 16'h0001.
